frame_reader: RTL and testbench

Memory-to-host readout engine for the camera datapath. On a start pulse it fetches a stored frame from DDR through the MIG read port in fixed bursts of 64-bit words. It buffers the words in a small show-ahead FIFO and presents them on a valid/ready stream toward the host pipe-out logic. It is the read-side counterpart of the pixel capture path: it consumes frames that the capture path wrote at the same word-address granularity.

---
 rtl/camera_pkg.sv | 24 ++
 rtl/sync_fifo_sa.sv | 76 +++++++
 rtl/frame_reader.sv | 167 ++++++++++++++++
 tb/tb_frame_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : camera_pkg
//  Description : Shared types and default constants for the camera datapath
//                (frame capture and frame readout).
//  Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // Default 64-bit words per memory burst and UI address step per burst.
    localparam int c_burst_len      = 8;
    localparam int c_addr_increment = 8;

    // Readout engine states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } reader_state_t;

endpackage : camera_pkg
`default_nettype wire

// File: rtl/sync_fifo_sa.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_sa
//  Description : Single-clock show-ahead FIFO. The head word is presented on
//                rd_data whenever the FIFO is not empty. Writes to a full
//                FIFO and reads from an empty FIFO are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_sa #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_wr_ok = wr_en && !full;
    assign w_rd_ok = rd_en && !empty;

    // Storage array, written without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow must never happen: the producer checks free space first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(wr_en && full));
        end
    end

endmodule : sync_fifo_sa
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_reader
//  Description : Reads a stored frame from DDR in fixed bursts through the
//                memory UI read port, buffers the words in a show-ahead FIFO
//                and streams them to the host with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_reader
    import camera_pkg::*;
#(
    parameter int BURST_LEN      = c_burst_len,
    parameter int ADDR_INCREMENT = c_addr_increment,
    parameter int BUF_DEPTH      = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [29:0]                 start_addr,
    input  logic [23:0]                 frame_words,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        dropped,
    output logic                        mem_rd_req,
    output logic [23:0]                 mem_rd_addr,
    input  logic                        mem_rd_ack,
    input  logic [63:0]                 mem_rdata,
    input  logic                        mem_rdata_valid,
    output logic [63:0]                 dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(BUF_DEPTH):0]  buf_count
);

    localparam int                 c_cnt_w     = $clog2(BUF_DEPTH) + 1;
    localparam int                 c_beat_w    = $clog2(BURST_LEN);
    localparam logic [c_cnt_w-1:0] c_req_limit = c_cnt_w'(BUF_DEPTH - BURST_LEN);
    localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(BURST_LEN - 1);

    reader_state_t         r_state;
    reader_state_t         w_state_next;
    logic [23:0]           r_words_left;
    logic [c_beat_w-1:0]   r_beat_cnt;
    logic [23:0]           r_mem_rd_addr;
    logic                  r_dropped;
    logic                  w_push;
    logic                  w_buf_empty;
    logic                  w_buf_full;
    logic                  w_unused;

    // Only the 24-bit word address is used; the FIFO full flag is not needed
    // because a request is only issued when a whole burst fits.
    assign w_unused = ^{start_addr[29:27], start_addr[2:0], w_buf_full};

    assign busy        = (r_state != ST_IDLE);
    assign dropped     = r_dropped;
    assign mem_rd_addr = r_mem_rd_addr;
    assign dout_valid  = !w_buf_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus request, buffer-write and completion strobes.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        mem_rd_req   = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_words_left == '0) begin
                    w_state_next = ST_DONE;
                end else if (buf_count <= c_req_limit) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_rdata_valid) begin
                    // Beats past the end of the frame are discarded.
                    w_push = (r_words_left != '0);
                    if (r_beat_cnt == c_beat_last) begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                if (w_buf_empty) begin
                    frame_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame counters, burst address and stray-beat flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_words_left  <= '0;
            r_beat_cnt    <= '0;
            r_mem_rd_addr <= '0;
            r_dropped     <= 1'b0;
        end else begin
            r_dropped <= mem_rdata_valid && (r_state != ST_DATA);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mem_rd_addr <= start_addr[26:3];
                        r_words_left  <= frame_words;
                    end
                end
                ST_REQ: begin
                    if (mem_rd_ack) begin
                        r_beat_cnt    <= '0;
                        r_mem_rd_addr <= r_mem_rd_addr + 24'(ADDR_INCREMENT);
                    end
                end
                ST_DATA: begin
                    if (mem_rdata_valid) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_words_left != '0) begin
                            r_words_left <= r_words_left - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sync_fifo_sa #(
        .WIDTH (64),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (mem_rdata),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .empty   (w_buf_empty),
        .full    (w_buf_full),
        .count   (buf_count)
    );

endmodule : frame_reader
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_reader
//  Description : Self-checking bench for frame_reader with a memory responder
//                model and a scoreboard of expected output words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_reader;

    localparam int c_cnt_w = 6;

    logic               clk;
    logic               reset;
    logic               start;
    logic [29:0]        start_addr;
    logic [23:0]        frame_words;
    logic               busy;
    logic               frame_done;
    logic               dropped;
    logic               mem_rd_req;
    logic [23:0]        mem_rd_addr;
    logic               mem_rd_ack;
    logic [63:0]        mem_rdata;
    logic               mem_rdata_valid;
    logic [63:0]        dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [c_cnt_w-1:0] buf_count;

    frame_reader #(
        .BURST_LEN      (8),
        .ADDR_INCREMENT (8),
        .BUF_DEPTH      (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .frame_words     (frame_words),
        .busy            (busy),
        .frame_done      (frame_done),
        .dropped         (dropped),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_ack      (mem_rd_ack),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .buf_count       (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared state between the main sequence and the negedge responder/monitor.
    logic [63:0] exp_q[$];
    logic [23:0] addr_q[$];
    int ready_mode   = 0;   // 0 always, 1 alternate, 2 random, 3 hold low
    int rsp_abort    = 0;
    int stray_left   = 0;
    int beats_left   = 0;
    int ack_wait     = 0;
    logic [23:0] rsp_addr = '0;
    int pop_cnt      = 0;
    int pops_at_done = 0;
    int done_cnt     = 0;
    int drop_cnt     = 0;
    int req_cycles   = 0;
    int valid_seen   = 0;

    function automatic logic [63:0] mk_word(input logic [23:0] a, input logic [7:0] b);
        return {16'hCAFE, 8'h5A, a, 8'hA5, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder, host sink and event counters, all on the falling edge.
    always @(negedge clk) begin
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            2:       dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = 1'b0;
        endcase
        if (!reset && dout_valid && dout_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: actual=%0h required=no word", dout);
            end else begin
                chk("dout_word", dout, exp_q.pop_front());
            end
        end
        if (frame_done) begin
            done_cnt++;
            pops_at_done = pop_cnt;
        end
        if (dropped)    drop_cnt++;
        if (dout_valid) valid_seen = 1;
        if (mem_rd_req) req_cycles++;

        mem_rd_ack = 1'b0;
        if (rsp_abort != 0) begin
            beats_left      = 0;
            ack_wait        = 0;
            mem_rdata_valid = 1'b0;
        end else if (stray_left > 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = 64'hDEAD_BEEF_0000_0000 | 64'(stray_left);
            stray_left--;
        end else if (beats_left > 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = mk_word(rsp_addr, 8'(8 - beats_left));
            beats_left--;
        end else begin
            mem_rdata_valid = 1'b0;
            if (mem_rd_req) begin
                if (ack_wait == 3) begin
                    mem_rd_ack = 1'b1;
                    ack_wait   = 0;
                    rsp_addr   = mem_rd_addr;
                    addr_q.push_back(mem_rd_addr);
                    beats_left = 8;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    task automatic clear_counts();
        addr_q.delete();
        pop_cnt      = 0;
        pops_at_done = 0;
        done_cnt     = 0;
        drop_cnt     = 0;
        req_cycles   = 0;
    endtask

    // Drive start for one cycle (call at posedge+1) and load the scoreboard.
    task automatic launch(input logic [29:0] a, input int n);
        logic [23:0] base;
        base        = a[26:3];
        start       = 1'b1;
        start_addr  = a;
        frame_words = 24'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_word(base + 24'(8 * (i / 8)), 8'(i % 8)));
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("frame_done_seen", 64'(done_cnt != 0), 64'd1);
    endtask

    typedef struct {
        logic [29:0] addr;
        int          words;
        int          rmode;
        int          bursts;
        logic [23:0] a_first;
        logic [23:0] a_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{30'h0000_0100, 16, 0, 2, 24'h000020, 24'h000028};
        vecs[1] = '{30'h0000_0200, 10, 0, 2, 24'h000040, 24'h000048};
        vecs[2] = '{30'h0000_1008,  3, 1, 1, 24'h000201, 24'h000201};
        vecs[3] = '{30'h3FFF_FFC0, 24, 2, 3, 24'hFFFFF8, 24'h000008};
        vecs[4] = '{30'h0000_0040,  8, 0, 1, 24'h000008, 24'h000008};

        reset = 1'b1; start = 1'b0; start_addr = '0; frame_words = '0;
        mem_rd_ack = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0; dout_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_frame_done", 64'(frame_done), 0);
        chk("rst_dropped", 64'(dropped), 0);
        chk("rst_mem_rd_req", 64'(mem_rd_req), 0);
        chk("rst_dout_valid", 64'(dout_valid), 0);
        chk("rst_mem_rd_addr", 64'(mem_rd_addr), 0);
        chk("rst_buf_count", 64'(buf_count), 0);
        reset = 1'b0;
        step();

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            clear_counts();
            ready_mode = vecs[v].rmode;
            launch(vecs[v].addr, vecs[v].words);
            chk("busy_cycle1", 64'(busy), 1);
            chk("req_cycle1", 64'(mem_rd_req), 0);
            step();
            chk("req_cycle2", 64'(mem_rd_req), 1);
            wait_done(2000);
            step();
            step();
            chk("bursts", 64'(addr_q.size()), 64'(vecs[v].bursts));
            chk("addr_first", 64'(addr_q.size() > 0 ? addr_q[0] : 24'hx), 64'(vecs[v].a_first));
            chk("addr_last", 64'(addr_q.size() > 0 ? addr_q[$] : 24'hx), 64'(vecs[v].a_last));
            chk("pops", 64'(pop_cnt), 64'(vecs[v].words));
            chk("pops_at_done", 64'(pops_at_done), 64'(vecs[v].words));
            chk("done_count", 64'(done_cnt), 1);
            chk("busy_end", 64'(busy), 0);
            chk("buf_count_end", 64'(buf_count), 0);
            chk("scoreboard_empty", 64'(exp_q.size()), 0);
            chk("no_dropped", 64'(drop_cnt), 0);
        end

        // Zero-length frame: no requests, frame_done two cycles after start.
        clear_counts();
        ready_mode = 0;
        launch(30'h100, 0);
        chk("zero_busy_c1", 64'(busy), 1);
        chk("zero_done_c1", 64'(frame_done), 0);
        step();
        chk("zero_done_c2", 64'(frame_done), 1);
        step();
        chk("zero_busy_c3", 64'(busy), 0);
        chk("zero_done_c3", 64'(frame_done), 0);
        chk("zero_no_req", 64'(req_cycles), 0);

        // Back-pressure: buffer fills after four bursts, then requests resume.
        clear_counts();
        ready_mode = 3;
        launch(30'h0, 64);
        n = 0;
        while (!(addr_q.size() == 4 && buf_count == 6'd32) && n < 1000) begin
            step();
            n++;
        end
        repeat (40) step();
        chk("bp_bursts_stalled", 64'(addr_q.size()), 4);
        chk("bp_req_low", 64'(mem_rd_req), 0);
        chk("bp_buf_full", 64'(buf_count), 32);
        ready_mode = 0;
        wait_done(3000);
        step();
        chk("bp_bursts_total", 64'(addr_q.size()), 8);
        chk("bp_pops", 64'(pop_cnt), 64);
        chk("bp_scoreboard", 64'(exp_q.size()), 0);

        // Start while busy is ignored.
        clear_counts();
        ready_mode = 0;
        launch(30'h100, 16);
        n = 0;
        while (addr_q.size() < 1 && n < 200) begin
            step();
            n++;
        end
        start = 1'b1; start_addr = 30'h800; frame_words = 24'd5;
        step();
        start = 1'b0;
        wait_done(2000);
        step();
        chk("mid_bursts", 64'(addr_q.size()), 2);
        chk("mid_addr0", 64'(addr_q.size() > 0 ? addr_q[0] : 24'hx), 64'h20);
        chk("mid_addr1", 64'(addr_q.size() > 1 ? addr_q[1] : 24'hx), 64'h28);
        chk("mid_pops", 64'(pop_cnt), 16);
        chk("mid_done_count", 64'(done_cnt), 1);

        // Reset during DATA, then stray beats.
        clear_counts();
        ready_mode = 3;
        launch(30'h100, 16);
        n = 0;
        while (beats_left != 4 && n < 200) begin
            step();
            n++;
        end
        chk("rstdata_reached", 64'(beats_left), 4);
        reset = 1'b1;
        rsp_abort = 1;
        step();
        reset = 1'b0;
        rsp_abort = 0;
        exp_q.delete();
        drop_cnt = 0;
        valid_seen = 0;
        chk("rstdata_busy", 64'(busy), 0);
        chk("rstdata_req", 64'(mem_rd_req), 0);
        chk("rstdata_buf_flushed", 64'(buf_count), 0);
        stray_left = 4;
        repeat (10) step();
        chk("stray_dropped", 64'(drop_cnt), 4);
        chk("stray_no_valid", 64'(valid_seen), 0);
        chk("stray_buf_count", 64'(buf_count), 0);
        chk("stray_idle", 64'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_frame_reader
`default_nettype wire
